// File: rtl/mem_port_pkg.sv
// Shared types and constants for the single external memory port arbiter.
package mem_port_pkg;

  typedef enum logic [1:0] {
    MP_IDLE  = 2'd0,
    MP_FETCH = 2'd1,
    MP_DATA  = 2'd2
  } mp_state_t;

  localparam logic [1:0]  SIZE_B   = 2'b00;
  localparam logic [1:0]  SIZE_H   = 2'b01;
  localparam logic [1:0]  SIZE_W   = 2'b10;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mem_port_watchdog.sv
// Grant watchdog: loaded on each grant, counts down on wait cycles and flags
// expiry on the TIMEOUT-th consecutive wait cycle.
module mem_port_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  input  logic ack_n,
  output logic expired
);

  localparam logic [15:0] LOAD = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (active && ack_n && (cnt != '0)) begin
      cnt <= cnt - 16'd1;
    end
  end

  // Terminal count reached while still waiting: this edge is the last one.
  assign expired = active & ack_n & (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered external memory port between instruction fetch and
// data accesses, data first, alternating on completion, with a watchdog abort.
//
// state    | meaning
// MP_IDLE  | no grant; bus_req low
// MP_FETCH | fetch granted; bus holds if_addr, word read
// MP_DATA  | data granted; bus holds the d_* fields
import mem_port_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic        bus_req,
  output logic        bus_write,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack_n,
  output logic        bus_err
);

  mp_state_t state;
  logic      busy, ack, expired, done;
  logic      if_pend, d_pend, grant_f, grant_d;

  assign if_stall = if_req & ~if_ready;
  assign d_stall  = d_req & ~d_ready;

  // A request whose ready is pulsing right now is the one just served.
  assign if_pend = if_stall;
  assign d_pend  = d_stall;

  assign busy = (state != MP_IDLE);
  assign ack  = ~bus_ack_n;
  assign done = busy & (ack | expired);

  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    case (state)
      MP_IDLE: begin
        grant_d = d_pend;
        grant_f = ~d_pend & if_pend;
      end
      MP_FETCH: grant_d = done & d_pend;
      MP_DATA:  grant_f = done & if_pend;
      default: ;
    endcase
  end

  mem_port_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (grant_f | grant_d),
    .active  (busy),
    .ack_n   (bus_ack_n),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MP_IDLE;
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_size  <= 2'b00;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;

      if (done) begin
        state     <= MP_IDLE;
        bus_req   <= 1'b0;
        bus_write <= 1'b0;
        bus_size  <= 2'b00;
        bus_addr  <= '0;
        bus_wdata <= '0;
        if (state == MP_FETCH) begin
          if_rdata <= ack ? bus_rdata : NOP_INSN;
          if_ready <= 1'b1;
        end else begin
          if (!bus_write) d_rdata <= ack ? bus_rdata : '0;
          d_ready <= 1'b1;
        end
        if (!ack) bus_err <= 1'b1;
      end

      // A grant on a completion edge overrides the return to idle above.
      if (grant_d) begin
        state     <= MP_DATA;
        bus_req   <= 1'b1;
        bus_write <= d_write;
        bus_size  <= d_size;
        bus_addr  <= d_addr;
        bus_wdata <= d_write ? d_wdata : '0;
      end else if (grant_f) begin
        state     <= MP_FETCH;
        bus_req   <= 1'b1;
        bus_write <= 1'b0;
        bus_size  <= SIZE_W;
        bus_addr  <= if_addr;
        bus_wdata <= '0;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single external memory port between the instruction-fetch requester (IF stage / `pc_reg` side) and the data requester (MEM stage). It replaces the separate `IAD`/`IDT`/`ACKI_n` and `DAD`/`DDT`/`ACKD_n` buses with one registered bus. It grants one transaction at a time, returns read data with a one-cycle ready pulse, and drives per-requester stall signals into the pipeline stall logic. A watchdog aborts transactions whose acknowledge never arrives.

## Interface
- `TIMEOUT`, default 255: maximum cycles a granted transaction may wait for `bus_ack_n`. Legal range 1..65535.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `if_req` in 1: fetch request. Held high until `if_ready`.
- `if_addr` in 32: fetch address. Stable while `if_req` is high.
- `if_rdata` out 32: fetched instruction. Valid with `if_ready` and held until the next fetch completes.
- `if_ready` out 1: one-cycle pulse when the fetch completes.
- `if_stall` out 1: `if_req & ~if_ready`.
- `d_req` in 1: data request (MREQ). Held high until `d_ready`.
- `d_write` in 1: 1 = store, 0 = load.
- `d_size` in 2: access size, passed through unchanged.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data. Valid with `d_ready` and held until the next data completion.
- `d_ready` out 1: one-cycle completion pulse.
- `d_stall` out 1: `d_req & ~d_ready`.
- `bus_req` out 1: external request.
- `bus_write` out 1: external write strobe.
- `bus_size` out 2: external access size.
- `bus_addr` out 32: external address.
- `bus_wdata` out 32: external write data.
- `bus_rdata` in 32: external read data. Sampled on the acknowledge edge.
- `bus_ack_n` in 1: 0 = transaction complete this cycle.
- `bus_err` out 1: sticky timeout flag. Cleared only by reset.

## Operation
- FSM states: `IDLE`, `FETCH`, `DATA`.
- `IDLE`:
  - if `d_req` → `DATA`;
  - else if `if_req` → `FETCH`;
  - else stay in `IDLE`. Data has priority.
- On entering `FETCH`, the bus registers load `if_addr`, `write=0`, `size=2'b10`, `req=1`.
- On entering `DATA`, the bus registers load the `d_*` fields and `req=1`.
- Bus outputs come only from these registers and remain stable for the whole grant.
- Completion occurs at the edge where `bus_ack_n==0` in `FETCH`/`DATA`:
  - capture `bus_rdata` into `if_rdata`/`d_rdata`; a store capture leaves `d_rdata` unchanged;
  - pulse that requester's ready in the next cycle;
  - clear `bus_req`.
- Next state after completion:
  - if the *other* requester is pending, go directly to its grant state;
  - otherwise go to `IDLE`.
- The arbiter never re-grants the same requester on its own completion edge. This alternation prevents starvation of fetch under continuous loads.
- Watchdog: a 16-bit counter resets on each grant and increments while `bus_ack_n==1`. When it reaches `TIMEOUT`, the transaction aborts:
  - abort is treated as a completion with captured data 32'h0000_0013 (NOP) for fetch or 32'h0 for data;
  - `bus_err` is set.
- `bus_wdata` is don't-care for reads and is driven as 0.

## Timing
- Reset values:
  - state `IDLE`;
  - all bus outputs 0;
  - `if_rdata` = `d_rdata` = 0;
  - `if_ready` = `d_ready` = 0;
  - `bus_err` = 0;
  - watchdog counter 0.
- A request in cycle N with the FSM in `IDLE` gives `bus_req` high in cycle N+1.
- An acknowledge sampled at the end of cycle K gives ready high and `bus_req` low in cycle K+1.
- Zero-wait memory (ack in the first granted cycle): latency 2 cycles from request to ready. Maximum single-requester rate is one transaction per 3 cycles.
- Simultaneous requests in `IDLE`: data is served first, then fetch follows with no `IDLE` cycle between them.
- A requester that drops its request mid-grant is ignored; the transaction still completes.
- Ack and watchdog expiry on the same edge: the ack wins, and `bus_err` is not set.
- Reset mid-transaction: immediate return to reset values, with `bus_req` low asynchronously.

## Structure
- Shared package `mem_port_pkg`:
  - state encoding `MP_IDLE=2'd0`, `MP_FETCH=2'd1`, `MP_DATA=2'd2`;
  - size constants `SIZE_B=2'b00`, `SIZE_H=2'b01`, `SIZE_W=2'b10`;
  - `NOP_INSN=32'h0000_0013`.
- One sub-module, `mem_port_watchdog`: counter, clear-on-grant, expiry output.

## Test plan
- Single fetch, ack in the first granted cycle: `if_addr=0x100` → `bus_addr=0x100` in cycle 1, `if_ready` in cycle 2, `if_rdata=bus_rdata`.
- Fetch and store requested together in cycle 0:
  - `DATA` is granted first with `bus_write=1`, `bus_wdata=d_wdata`;
  - after its ack, `FETCH` is granted the next cycle with no `IDLE` gap.
- Continuous `d_req` plus `if_req`: grants alternate `D,F,D,F`, and the fetch is never starved beyond one data transaction.
- Memory with 3 wait states: `bus_req` and all bus fields are stable for 4 cycles; `d_stall` is high until `d_ready`.
- `TIMEOUT=4`, ack never arrives:
  - abort after 4 wait cycles, with `if_rdata=0x00000013`, `if_ready` pulsing, and `bus_err` becoming 1 and staying 1;
  - a following transaction works normally.
- `rst_n` asserted during a wait state: `bus_req` drops immediately and all outputs return to reset values.
